vc_credit_sender: RTL and testbench
===================================

Name: vc_credit_sender

Overview:
- Transmit end of a credit-based link that feeds a remote receive queue of depth p_num_credits.
- Accepts domain-tagged messages on a val/rdy interface and sends them on a registered push interface. The push interface has out_val and no ready; each send consumes one credit, and the receiver returns credits one at a time.
- Enforces domain isolation: the remote queue never holds messages from two security domains at once. Before the first message of a new domain is sent, all credits must have returned.

Parameters:
- p_msg_nbits, 32, message payload width in bits.
- p_num_credits, 2, remote queue depth and initial credit count (must be >= 1).
- c_cnt_nbits, $clog2(p_num_credits+1), credit counter width; local, not set from outside.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-low (0 = reset).
- in_domain, in, 1, security domain of in_msg.
- in_val, in, 1, input message valid.
- in_rdy, out, 1, sender will accept in_msg this cycle.
- in_msg, in, p_msg_nbits, input payload.
- out_val, out, 1, registered send strobe, one cycle per message.
- out_domain, out, 1, registered domain of out_msg.
- out_msg, out, p_msg_nbits, registered payload.
- credit_return, in, 1, receiver freed one entry (pulse, at most one per cycle).
- credit_count, out, c_cnt_nbits, current credits held.
- cur_domain, out, 1, domain currently owning the link.
- draining, out, 1, high while in DRAIN state.
- credit_err, out, 1, sticky: a credit was returned while the count was at p_num_credits.

Behaviour:
- Reset (reset==0 at a posedge), applied regardless of state:
  - credit_count = p_num_credits, cur_domain = 0, state = ACTIVE.
  - out_val = 0, out_msg = 0, out_domain = 0, credit_err = 0.
  - Reset mid-drain or mid-send discards any in-flight bookkeeping.
- State machine with two states, ACTIVE and DRAIN.
- in_rdy is asserted only when all of the following hold:
  - state == ACTIVE;
  - credit_count != 0;
  - in_domain == cur_domain, or credit_count == p_num_credits.
- in_rdy is combinational from state, credit_count, cur_domain and in_domain. It does not depend on in_val or on the same-cycle credit_return (no credit bypass).
- do_send = in_val && in_rdy.
- On do_send:
  - next cycle out_val = 1, out_msg = in_msg, out_domain = in_domain;
  - cur_domain <= in_domain (changes only when the link is empty).
- Without do_send, out_val = 0 next cycle. out_msg and out_domain hold their last values.
- Send latency is exactly 1 cycle. Back-to-back sends are allowed every cycle while credits remain.
- Credit counter: next = credit_count - do_send + credit_return.
  - A send and a return in the same cycle leave the count unchanged.
- Credit overflow: credit_return while credit_count == p_num_credits and no do_send sets credit_err = 1. The count stays saturated at p_num_credits, and credit_err holds until reset.
- Underflow is impossible by construction, because do_send requires credit_count != 0.
- ACTIVE -> DRAIN: in_val && in_domain != cur_domain && credit_count != p_num_credits.
- DRAIN:
  - in_rdy = 0 and draining = 1; credit_return is counted normally.
  - Leaves to ACTIVE on the cycle after credit_count == p_num_credits is observed.
  - Completes even if in_val drops or in_domain reverts; there is no abort.
- After DRAIN -> ACTIVE, the pending mismatched-domain message is accepted on the first ACTIVE cycle, because the count is full.
- Same-domain traffic never enters DRAIN.
- Zero credits with a same-domain request: stay ACTIVE with in_rdy = 0 until a credit returns.

Test Plan:
- Reset, then in_val=1, domain 0, msg 0xA5 for 3 cycles, no returns, p_num_credits=2 -> two out_val pulses carry 0xA5; credit_count goes 2→1→0; in_rdy=0 on the 3rd cycle.
- credit_count=0 and credit_return pulses once -> credit_count=1 next cycle, in_rdy=1, the next send fires; a send and a return in the same cycle hold credit_count=1.
- Domain switch: cur_domain=0, credit_count=1, in_val with domain 1 -> draining=1 and in_rdy=0. After one return, credit_count=2; ACTIVE the next cycle; the message is sent with out_domain=1 and cur_domain=1.
- Domain switch with full credits (count=2, domain 1 request) -> immediate send, no DRAIN cycle.
- credit_return with credit_count=2 and no send -> credit_err=1 (sticky), credit_count remains 2.
- Reset (reset=0) asserted during DRAIN with credit_count=0 -> next cycle state=ACTIVE, credit_count=2, out_val=0, credit_err=0, cur_domain=0.

Source files
------------

// File: rtl/vc_credit_sender.sv
// Transmit side of a credit-based link with security-domain isolation.
// Before switching domains, the sender waits for every credit to come back.
module vc_credit_sender #(
   parameter int unsigned p_msg_nbits   = 32,
   parameter int unsigned p_num_credits = 2,
   localparam int unsigned c_cnt_nbits  = $clog2(p_num_credits + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_domain,
   input  logic                   in_val,
   output logic                   in_rdy,
   input  logic [p_msg_nbits-1:0] in_msg,
   output logic                   out_val,
   output logic                   out_domain,
   output logic [p_msg_nbits-1:0] out_msg,
   input  logic                   credit_return,
   output logic [c_cnt_nbits-1:0] credit_count,
   output logic                   cur_domain,
   output logic                   draining,
   output logic                   credit_err
);

   localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_credits);
   localparam logic [c_cnt_nbits-1:0] c_one  = c_cnt_nbits'(1);

   typedef enum logic [0:0] {StActive, StDrain} state_e;

   state_e                 state_q, state_d;
   logic [c_cnt_nbits-1:0] credit_count_q, credit_count_d;
   logic                   cur_domain_q, cur_domain_d;
   logic                   out_val_q, out_val_d;
   logic                   out_domain_q, out_domain_d;
   logic [p_msg_nbits-1:0] out_msg_q, out_msg_d;
   logic                   credit_err_q, credit_err_d;

   logic link_empty;
   logic do_send;

   assign link_empty = (credit_count_q == c_full);

   // A different domain may only be accepted once the remote queue is empty.
   assign in_rdy  = (state_q == StActive) && (credit_count_q != '0) &&
                    ((in_domain == cur_domain_q) || link_empty);
   assign do_send = in_val && in_rdy;

   always_comb begin
      state_d        = state_q;
      credit_count_d = credit_count_q;
      credit_err_d   = credit_err_q;
      cur_domain_d   = cur_domain_q;
      out_val_d      = do_send;
      out_msg_d      = out_msg_q;
      out_domain_d   = out_domain_q;

      if (do_send) begin
         out_msg_d    = in_msg;
         out_domain_d = in_domain;
         cur_domain_d = in_domain;
      end

      // A send and a return in the same cycle cancel out.
      if (do_send && !credit_return) begin
         credit_count_d = credit_count_q - c_one;
      end else if (!do_send && credit_return) begin
         if (link_empty) begin
            credit_err_d = 1'b1;
         end else begin
            credit_count_d = credit_count_q + c_one;
         end
      end

      unique case (state_q)
         StActive: begin
            if (in_val && (in_domain != cur_domain_q) && !link_empty) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (link_empty) begin
               state_d = StActive;
            end
         end
         default: state_d = StActive;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= StActive;
         credit_count_q <= c_full;
         cur_domain_q   <= 1'b0;
         out_val_q      <= 1'b0;
         out_msg_q      <= '0;
         out_domain_q   <= 1'b0;
         credit_err_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_count_q <= credit_count_d;
         cur_domain_q   <= cur_domain_d;
         out_val_q      <= out_val_d;
         out_msg_q      <= out_msg_d;
         out_domain_q   <= out_domain_d;
         credit_err_q   <= credit_err_d;
      end
   end

   assign out_val      = out_val_q;
   assign out_msg      = out_msg_q;
   assign out_domain   = out_domain_q;
   assign credit_count = credit_count_q;
   assign cur_domain   = cur_domain_q;
   assign draining     = (state_q == StDrain);
   assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_vc_credit_sender.sv
// Directed, table-driven bench for vc_credit_sender with two credits.
// Each vector is one clock: in_rdy is checked before the edge, registered outputs after it.
module tb_vc_credit_sender;

   logic        clk;
   logic        reset;
   logic        in_domain;
   logic        in_val;
   logic        in_rdy;
   logic [31:0] in_msg;
   logic        out_val;
   logic        out_domain;
   logic [31:0] out_msg;
   logic        credit_return;
   logic [1:0]  credit_count;
   logic        cur_domain;
   logic        draining;
   logic        credit_err;

   int n_pass;
   int n_total;

   typedef struct {
      logic        rst_n;
      logic        val;
      logic        dom;
      logic [31:0] msg;
      logic        ret;
      logic        e_rdy;
      logic        e_oval;
      logic [31:0] e_omsg;
      logic        e_odom;
      logic [1:0]  e_cnt;
      logic        e_cdom;
      logic        e_drain;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   vc_credit_sender #(
      .p_msg_nbits  (32),
      .p_num_credits(2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .in_domain    (in_domain),
      .in_val       (in_val),
      .in_rdy       (in_rdy),
      .in_msg       (in_msg),
      .out_val      (out_val),
      .out_domain   (out_domain),
      .out_msg      (out_msg),
      .credit_return(credit_return),
      .credit_count (credit_count),
      .cur_domain   (cur_domain),
      .draining     (draining),
      .credit_err   (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input int idx, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL v%0d %s: got %0h, expected %0h", idx, name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic add(input logic rst_n, input logic val, input logic dom, input logic [31:0] msg,
                      input logic ret, input logic e_rdy, input logic e_oval,
                      input logic [31:0] e_omsg, input logic e_odom, input logic [1:0] e_cnt,
                      input logic e_cdom, input logic e_drain, input logic e_err);
      vec_t v;
      v = '{rst_n, val, dom, msg, ret, e_rdy, e_oval, e_omsg, e_odom, e_cnt, e_cdom, e_drain,
            e_err};
      vecs.push_back(v);
   endtask

   task automatic check_outputs(input int idx, input vec_t v);
      check(idx, "out_val", 32'(out_val), 32'(v.e_oval));
      check(idx, "out_msg", out_msg, v.e_omsg);
      check(idx, "out_domain", 32'(out_domain), 32'(v.e_odom));
      check(idx, "credit_count", 32'(credit_count), 32'(v.e_cnt));
      check(idx, "cur_domain", 32'(cur_domain), 32'(v.e_cdom));
      check(idx, "draining", 32'(draining), 32'(v.e_drain));
      check(idx, "credit_err", 32'(credit_err), 32'(v.e_err));
   endtask

   initial begin
      vec_t rst_exp;
      n_pass  = 0;
      n_total = 0;

      // Columns: rst_n val dom msg ret | rdy(pre-edge) oval omsg odom cnt cdom drain err
      // Three same-domain sends with no returns: count 2 -> 1 -> 0, third blocked.
      add(1, 1, 0, 32'hA5, 0,  1, 1, 32'hA5, 0, 2'd1, 0, 0, 0);
      add(1, 1, 0, 32'hA5, 0,  1, 1, 32'hA5, 0, 2'd0, 0, 0, 0);
      add(1, 1, 0, 32'hA5, 0,  0, 0, 32'hA5, 0, 2'd0, 0, 0, 0);
      // One return at zero credits, then send + return in the same cycle.
      add(1, 0, 0, 32'h00, 1,  0, 0, 32'hA5, 0, 2'd1, 0, 0, 0);
      add(1, 1, 0, 32'h11, 1,  1, 1, 32'h11, 0, 2'd1, 0, 0, 0);
      // Domain switch with one credit out: drain, survive in_val drop, then send.
      add(1, 1, 1, 32'h33, 0,  0, 0, 32'h11, 0, 2'd1, 0, 1, 0);
      add(1, 1, 1, 32'h33, 0,  0, 0, 32'h11, 0, 2'd1, 0, 1, 0);
      add(1, 0, 0, 32'h00, 1,  0, 0, 32'h11, 0, 2'd2, 0, 1, 0);
      add(1, 1, 1, 32'h33, 0,  0, 0, 32'h11, 0, 2'd2, 0, 0, 0);
      add(1, 1, 1, 32'h33, 0,  1, 1, 32'h33, 1, 2'd1, 1, 0, 0);
      // Refill, then a domain switch at full credits goes out immediately.
      add(1, 0, 1, 32'h00, 1,  1, 0, 32'h33, 1, 2'd2, 1, 0, 0);
      add(1, 1, 0, 32'h44, 0,  1, 1, 32'h44, 0, 2'd1, 0, 0, 0);
      // Overflow return sets a sticky error; count stays saturated.
      add(1, 0, 0, 32'h00, 1,  1, 0, 32'h44, 0, 2'd2, 0, 0, 0);
      add(1, 0, 0, 32'h00, 1,  1, 0, 32'h44, 0, 2'd2, 0, 0, 1);
      add(1, 0, 0, 32'h00, 0,  1, 0, 32'h44, 0, 2'd2, 0, 0, 1);
      // Empty the credits, enter drain, then reset mid-drain.
      add(1, 1, 0, 32'h55, 0,  1, 1, 32'h55, 0, 2'd1, 0, 0, 1);
      add(1, 1, 0, 32'h66, 0,  1, 1, 32'h66, 0, 2'd0, 0, 0, 1);
      add(1, 1, 1, 32'h77, 0,  0, 0, 32'h66, 0, 2'd0, 0, 1, 1);
      add(0, 1, 1, 32'h77, 0,  0, 0, 32'h00, 0, 2'd2, 0, 0, 0);
      // Send in domain 1 after reset, then reset while a send is outstanding.
      add(1, 1, 1, 32'h88, 0,  1, 1, 32'h88, 1, 2'd1, 1, 0, 0);
      add(0, 0, 1, 32'h00, 0,  1, 0, 32'h00, 0, 2'd2, 0, 0, 0);
      add(1, 1, 1, 32'h99, 0,  1, 1, 32'h99, 1, 2'd1, 1, 0, 0);

      // Initial reset, held for two edges.
      reset         = 1'b0;
      in_val        = 1'b0;
      in_domain     = 1'b0;
      in_msg        = 32'h0;
      credit_return = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_exp = '{0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 0, 2'd2, 0, 0, 0};
      check_outputs(-1, rst_exp);
      check(-1, "in_rdy", 32'(in_rdy), 32'(1'b1));

      foreach (vecs[i]) begin
         @(negedge clk);
         reset         = vecs[i].rst_n;
         in_val        = vecs[i].val;
         in_domain     = vecs[i].dom;
         in_msg        = vecs[i].msg;
         credit_return = vecs[i].ret;
         #1;
         check(i, "in_rdy", 32'(in_rdy), 32'(vecs[i].e_rdy));
         @(posedge clk);
         #1;
         check_outputs(i, vecs[i]);
      end

      // Back-to-back sends with a return every cycle hold the count at one.
      @(negedge clk);
      reset         = 1'b1;
      in_val        = 1'b1;
      in_domain     = 1'b1;
      credit_return = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_msg = 32'hC0 + 32'(k);
         @(posedge clk);
         #1;
         check(100 + k, "b2b out_val", 32'(out_val), 32'(1'b1));
         check(100 + k, "b2b out_msg", out_msg, 32'hC0 + 32'(k));
         check(100 + k, "b2b credit_count", 32'(credit_count), 32'd1);
         @(negedge clk);
      end
      in_val        = 1'b0;
      credit_return = 1'b0;
      @(posedge clk);
      #1;
      check(104, "idle out_val", 32'(out_val), 32'(1'b0));
      check(104, "idle out_msg held", out_msg, 32'hC3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
